// File: rtl/instr_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the fetch FSM encoding, width defaults, the reset PC and the NOP word.
package instr_fetch_pkg;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_INSTR_W  = 16;
  localparam int DEF_RESET_PC = 0;

  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// hands one instruction at a time to the control unit, honouring redirect and halt.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted,
  output fetch_state_e       dbg_state
);

  // Handshakes: memory transfer completes in the single cycle mem_ack=1 while
  // mem_req=1 (mem_addr held stable until then); the control unit consumes the
  // instruction in a cycle with instr_valid=1 and instr_ready=1, unless redirect=1.

  fetch_state_e       state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n, pc_inc;
  logic [ADDR_W-1:0]  mem_addr_n, instr_pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic               mem_req_n, instr_valid_n, halted_n;
  logic               drop, drop_n;
  logic               halt_pend, halt_pend_n, halt_now;

  assign halt_now  = halt | halt_pend;
  assign pc_inc    = pc + ADDR_W'(1);
  assign dbg_state = state;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    mem_req_n     = mem_req;
    mem_addr_n    = mem_addr;
    instr_valid_n = instr_valid;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    halted_n      = halted;
    drop_n        = drop;
    halt_pend_n   = halt_now;
    case (state)
      ST_IDLE: begin
        if (halt_now) begin
          state_n  = ST_HALTED;
          halted_n = 1'b1;
        end else begin
          state_n   = ST_REQ;
          mem_req_n = 1'b1;
          if (redirect) begin
            pc_n       = redirect_pc;
            mem_addr_n = redirect_pc;
          end else begin
            mem_addr_n = pc;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          drop_n = 1'b0;
          if (halt_now) begin
            state_n   = ST_HALTED;
            mem_req_n = 1'b0;
            halted_n  = 1'b1;
          end else if (redirect) begin
            pc_n       = redirect_pc;
            mem_addr_n = redirect_pc;
          end else if (drop) begin
            // Stale data from before a redirect; pc already holds the target.
            mem_addr_n = pc;
          end else begin
            instr_n       = mem_rdata;
            instr_pc_n    = mem_addr;
            instr_valid_n = 1'b1;
            mem_req_n     = 1'b0;
            state_n       = ST_HOLD;
          end
        end else if (redirect) begin
          drop_n = 1'b1;
          pc_n   = redirect_pc;
        end
      end
      ST_HOLD: begin
        if (redirect || instr_ready) begin
          instr_valid_n = 1'b0;
          pc_n          = redirect ? redirect_pc : pc_inc;
          if (halt_now) begin
            state_n  = ST_HALTED;
            halted_n = 1'b1;
          end else begin
            state_n    = ST_REQ;
            mem_req_n  = 1'b1;
            mem_addr_n = redirect ? redirect_pc : pc_inc;
          end
        end
      end
      ST_HALTED: begin
        mem_req_n     = 1'b0;
        instr_valid_n = 1'b0;
        halted_n      = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
      drop        <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      mem_req     <= mem_req_n;
      mem_addr    <= mem_addr_n;
      instr_valid <= instr_valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      halted      <= halted_n;
      drop        <= drop_n;
      halt_pend   <= halt_pend_n;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the control unit. It holds the program counter, fetches instructions from instruction memory over a request/acknowledge handshake, and presents one instruction at a time to the control unit with a valid/ready handshake. It also accepts branch/jump redirects and a halt request from the control unit.

## Interface
- ADDR_W, 16, instruction address width (word-addressed)
- INSTR_W, 16, instruction width
- RESET_PC, 0, PC value loaded at reset

- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- mem_req  out  1  instruction memory read request
- mem_addr  out  ADDR_W  read address; stable while mem_req=1
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in that cycle
- mem_rdata  in  INSTR_W  fetched instruction word
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr_ready  in  1  control unit consumes the instruction this cycle
- instr  out  INSTR_W  instruction to control unit
- instr_pc  out  ADDR_W  address of instr
- redirect  in  1  branch/jump taken; discard sequential fetch
- redirect_pc  in  ADDR_W  new PC, sampled when redirect=1
- halt  in  1  stop fetching; sticky until reset
- halted  out  1  block is in HALTED

## Operation
- States: IDLE, REQ, HOLD, HALTED. All outputs are registered.
- Reset (rst_n=0 at a clock edge): state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, halted=0, drop=0.
- IDLE: go to REQ next cycle with mem_req=1, mem_addr=pc.
- REQ: hold mem_req and mem_addr until mem_ack. On mem_ack:
  - drop=0: capture instr=mem_rdata, instr_pc=mem_addr, then instr_valid=1 and go to HOLD.
  - drop=1: discard mem_rdata, clear drop, and issue a new request at pc (the redirect target).
- HOLD: instr_valid=1 until accepted.
  - On instr_ready: pc←pc+1, then go to REQ at the new pc, or to HALTED if a halt is pending.
- Redirect:
  - In REQ without same-cycle ack, the outstanding request is never aborted. Set drop=1 and pc←redirect_pc.
  - In REQ with same-cycle ack, discard the ack data and request redirect_pc next cycle.
  - In HOLD, set instr_valid=0, pc←redirect_pc, and go to REQ. Redirect beats a simultaneous instr_ready: the instruction is discarded, not consumed.
  - In IDLE, pc←redirect_pc.
  - In HALTED, ignored.
- Halt:
  - Latched into halt_pend.
  - In IDLE, go to HALTED.
  - In REQ, complete the outstanding handshake. Discard its data, then go to HALTED.
  - In HOLD, go to HALTED at the next instr_ready or redirect.
  - HALTED: mem_req=0, instr_valid=0, halted=1. Exit only by reset.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 with no flag.
- Reset mid-operation: takes effect at the next edge regardless of state, and abandons any outstanding request. The memory must tolerate a request being withdrawn.

## Timing
- Reset released before edge 0: IDLE at 0, mem_req=1 from cycle 1.
- Fetch latency: mem_ack in cycle k gives instr_valid=1 in cycle k+1.
- Accept at cycle j gives mem_req=1 (next address) in cycle j+1.
- Peak throughput with single-cycle memory: one instruction per 3 cycles (REQ, HOLD, REQ...).
- Redirect in cycle r with no outstanding request gives mem_addr=redirect_pc, mem_req=1 in cycle r+1.
- With an outstanding request, mem_addr=redirect_pc the cycle after the ack.
- instr, instr_pc: change only on capture, hold otherwise (not cleared on discard).

## Structure
- Shared package: fetch state enum (IDLE/REQ/HOLD/HALTED), ADDR_W/INSTR_W defaults, RESET_PC constant, and NOP encoding for bench use.
- Single module; no sub-module needed. PC register and FSM sit in one always block, plus next-state combinational logic.

## Test plan
- Reset release, memory acks after 1 cycle with 0x1234 → cycle 1 mem_req=1 addr 0x0000; cycle 3 instr_valid=1, instr=0x1234, instr_pc=0x0000.
- Three accepted fetches, ready held 1 → addresses 0,1,2 requested in order; instr_pc follows 0,1,2; valid never asserted twice for one fetch.
- Redirect to 0x0040 while a request is waiting (ack delayed 3 cycles) → mem_addr stays 0x0000 until ack; that data is never presented; next mem_addr=0x0040, presented instr_pc=0x0040.
- In HOLD, assert redirect=1 (to 0x0100) and instr_ready=1 in the same cycle → instr_valid drops next cycle; next request at 0x0100.
- Fetch PC 0xFFFF accepted → next mem_addr=0x0000.
- halt during REQ → ack completes; data dropped; halted=1, mem_req=0 permanently. rst_n=0 mid-REQ → next cycle all outputs at reset values.
